alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//   Sequential responder wrapping the pipeline ALU operation set behind a valid/ready request/response handshake.
//   Accepts one operation request, computes it, holds a registered result until the consumer takes it.
//   Sits between the decode/issue logic and writeback in the riscv pipeline; replaces the bare combinational ALU where backpressure is needed.
// PARAMETERS
//   WIDTH      32   operand/result width in bits
//   SHAMT_W    5    shift-amount width; must equal $clog2(WIDTH)
// PORTS
//   clk          in   1        rising-edge clock
//   rst          in   1        synchronous reset, active-high
//   req_valid    in   1        request present
//   req_ready    out  1        unit can accept a request this cycle
//   req_a        in   WIDTH    operand A
//   req_b        in   WIDTH    operand B
//   req_op       in   3        000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT, others per CONFIGURATION
//   rsp_valid    out  1        result register holds an untaken response
//   rsp_ready    in   1        consumer takes response this cycle
//   rsp_result   out  WIDTH    result
//   rsp_zero     out  1        rsp_result == 0
//   busy         out  1        state != IDLE or rsp_valid
// BEHAVIOUR
//   - Reset (sync, rst=1 at clk edge): state=IDLE, rsp_valid=0, rsp_result=0, rsp_zero=0, busy=0. Reset mid-operation aborts it; no response is produced.
//   - FSM: IDLE -> (accept single-cycle op) -> IDLE with rsp_valid=1; IDLE -> (accept shift op, SHAMT>0) -> CALC; CALC -> IDLE when remaining count reaches 0, loading response.
//   - Accept = req_valid & req_ready. req_ready = (state==IDLE) & (~rsp_valid | rsp_ready); combinational, valid/ready independent (req_ready never depends on req_valid).
//   - Single-cycle ops: response visible the cycle after accept (latency 1). Back-to-back throughput 1/cycle when rsp_ready held high.
//   - Response drain and new accept in the same cycle: old response retired, new one loaded; rsp_valid stays 1.
//   - rsp_valid & ~rsp_ready: rsp_result/rsp_zero held stable, req_ready=0, no new accept.
//   - Operands/op captured at accept; later changes on req_* ignored.
//   - ADD/SUB wrap modulo 2^WIDTH, no carry/overflow output. SUB = a - b.
//   - SLT: signed two's-complement compare; result = {WIDTH-1 zeros, (a<b)}.
//   - AND/OR bitwise. Undefined/disabled op codes: result 0, rsp_zero=1, latency 1.
//   - rsp_zero registered with rsp_result, always equals (rsp_result==0).
// CONFIGURATION
//   Macro ALU_SHIFT_EN:
//   - Defined: 100 SLL, 110 SRL, 111 SRA by b[SHAMT_W-1:0]. Iterative 1-bit/cycle shifter in CALC; latency = SHAMT+1 cycles (SHAMT=0 -> 1 cycle, no CALC).
//     req_ready=0 throughout CALC. SRA replicates a[WIDTH-1].
//   - Undefined: no CALC state or shifter logic synthesized; 100/110/111 are undefined ops (result 0, latency 1).
// TESTING
//   1. a=10, b=5, op=000, rsp_ready=1 -> rsp_valid next cycle, result=15, zero=0.
//   2. a=10, b=10, op=001 -> result=0, zero=1; a=0, b=1, op=001 -> result=32'hFFFFFFFF (wrap).
//   3. a=F0F0F0F0, b=0F0F0F0F: op=010 -> 00000000, zero=1; op=011 -> FFFFFFFF, zero=0; a=-1, b=1, op=101 -> result=1; a=5, b=-3, op=101 -> 0.
//   4. Backpressure: rsp_ready=0 after ADD 10+5 -> result 15 held 5 cycles, req_ready=0; raise rsp_ready with new req 1+1 -> next cycle result=2, rsp_valid continuous.
//   5. ALU_SHIFT_EN: a=1, b=31, op=100 -> req_ready low 31 cycles, result=80000000 at cycle 32; a=80000000, b=4, op=111 -> F8000000; without macro op=100 -> 0, zero=1, latency 1.
//   6. rst=1 during CALC (or with rsp_valid=1) -> next cycle rsp_valid=0, result=0, busy=0, req_ready=1; no stale response after reset.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Registered ALU responder with valid/ready request and response sides; single-cycle ops respond one cycle after accept.
// ALU_SHIFT_EN adds SLL/SRL/SRA, shifted 1 bit per cycle in CALC (SHAMT+1 cycles); requests stall while a response waits.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             busy
);

  if (SHAMT_W != $clog2(WIDTH)) begin : g_bad_shamt_w
    $error("alu_exec_unit: SHAMT_W must equal $clog2(WIDTH)");
  end

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  logic             accept;
  logic             start_shift;
  logic [WIDTH-1:0] alu_res;

  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;

`ifdef ALU_SHIFT_EN
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CALC = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [WIDTH-1:0]   sh_val_q, sh_val_d;
  logic [SHAMT_W-1:0] sh_cnt_q, sh_cnt_d;
  logic [1:0]         sh_op_q, sh_op_d;
  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;
  logic [WIDTH-1:0]   sh_next;

  assign shamt       = req_b[SHAMT_W-1:0];
  assign is_shift    = req_op[2] & (req_op[1:0] != 2'b01);
  assign start_shift = accept & is_shift & (shamt != '0);
  assign req_ready   = (state_q == ST_IDLE) & (~rsp_valid_q | rsp_ready);
  assign busy        = (state_q != ST_IDLE) | rsp_valid_q;

  // sh_op_q keeps req_op[1:0]: 00 SLL, 10 SRL, 11 SRA
  always_comb begin
    case (sh_op_q)
      2'b00:   sh_next = {sh_val_q[WIDTH-2:0], 1'b0};
      2'b10:   sh_next = {1'b0, sh_val_q[WIDTH-1:1]};
      default: sh_next = {sh_val_q[WIDTH-1], sh_val_q[WIDTH-1:1]};
    endcase
  end
`else
  assign start_shift = 1'b0;
  assign req_ready   = ~rsp_valid_q | rsp_ready;
  assign busy        = rsp_valid_q;
`endif

  assign accept = req_valid & req_ready;

  always_comb begin
    case (req_op)
      OP_ADD:  alu_res = req_a + req_b;
      OP_SUB:  alu_res = req_a - req_b;
      OP_AND:  alu_res = req_a & req_b;
      OP_OR:   alu_res = req_a | req_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(req_a) < $signed(req_b))};
`ifdef ALU_SHIFT_EN
      // Only zero-amount shifts take this path; the rest go through CALC.
      3'b100, 3'b110, 3'b111: alu_res = req_a;
`endif
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    rsp_valid_d  = rsp_valid_q & ~rsp_ready;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
`ifdef ALU_SHIFT_EN
    state_d  = state_q;
    sh_val_d = sh_val_q;
    sh_cnt_d = sh_cnt_q;
    sh_op_d  = sh_op_q;
    if (start_shift) begin
      state_d  = ST_CALC;
      sh_val_d = req_a;
      sh_cnt_d = shamt;
      sh_op_d  = req_op[1:0];
    end
    if (state_q == ST_CALC) begin
      sh_val_d = sh_next;
      sh_cnt_d = sh_cnt_q - SHAMT_W'(1);
      if (sh_cnt_q == SHAMT_W'(1)) begin
        state_d      = ST_IDLE;
        rsp_valid_d  = 1'b1;
        rsp_result_d = sh_next;
        rsp_zero_d   = (sh_next == '0);
      end
    end
`endif
    if (accept && !start_shift) begin
      rsp_valid_d  = 1'b1;
      rsp_result_d = alu_res;
      rsp_zero_d   = (alu_res == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
`ifdef ALU_SHIFT_EN
      state_q      <= ST_IDLE;
      sh_val_q     <= '0;
      sh_cnt_q     <= '0;
      sh_op_q      <= '0;
`endif
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
`ifdef ALU_SHIFT_EN
      state_q      <= state_d;
      sh_val_q     <= sh_val_d;
      sh_cnt_q     <= sh_cnt_d;
      sh_op_q      <= sh_op_d;
`endif
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed cases plus randomized requests against a behavioural model.
// Builds with or without ALU_SHIFT_EN; the model follows the same macro.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [2:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef ALU_SHIFT_EN
      3'd4: return a << b[4:0];
      3'd6: return a >> b[4:0];
      3'd7: return 32'($signed(a) >>> b[4:0]);
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [31:0] b, input logic [2:0] op);
`ifdef ALU_SHIFT_EN
    if ((op == 3'd4 || op == 3'd6 || op == 3'd7) && b[4:0] != 5'd0)
      return int'(b[4:0]) + 1;
`endif
    return 1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request through to response; the consumer holds off for 'stall' cycles.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [31:0] exp, input int stall, input string tag);
    int lat;
    int waits;
    waits     = 0;
    rsp_ready = (stall == 0);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    while (!req_ready && waits < 100) begin
      tick();
      waits++;
    end
    check({tag, "_req_ready_wait"}, 32'(waits < 100), 32'd1);
    tick();
    req_valid = 1'b0;
    req_a     = $urandom;
    req_b     = $urandom;
    req_op    = 3'($urandom_range(0, 7));
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      check({tag, "_calc_req_ready"}, 32'(req_ready), 32'd0);
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(ref_lat(b, op)));
    check({tag, "_result"}, rsp_result, exp);
    check({tag, "_zero"}, 32'(rsp_zero), 32'(exp == 32'd0));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_hold_result"}, rsp_result, exp);
      check({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    check({tag, "_drained"}, 32'(rsp_valid), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int          cnt;
    logic [31:0] ra, rb, rexp;
    logic [2:0]  rop;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_result", rsp_result, 32'd0);
    check("rst_zero", 32'(rsp_zero), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);

    issue(32'd10, 32'd5, 3'b000, 32'd15, 0, "add");
    issue(32'd10, 32'd10, 3'b001, 32'd0, 0, "sub_zero");
    issue(32'd0, 32'd1, 3'b001, 32'hFFFF_FFFF, 0, "sub_wrap");
    issue(32'hF0F0_F0F0, 32'h0F0F_0F0F, 3'b010, 32'h0000_0000, 0, "and");
    issue(32'hF0F0_F0F0, 32'h0F0F_0F0F, 3'b011, 32'hFFFF_FFFF, 0, "or");
    issue(32'hFFFF_FFFF, 32'd1, 3'b101, 32'd1, 0, "slt_neg");
    issue(32'd5, 32'hFFFF_FFFD, 3'b101, 32'd0, 0, "slt_pos");
`ifdef ALU_SHIFT_EN
    issue(32'd1, 32'd31, 3'b100, 32'h8000_0000, 0, "sll31");
    issue(32'h8000_0000, 32'd4, 3'b111, 32'hF800_0000, 0, "sra4");
    issue(32'h8000_0000, 32'd4, 3'b110, 32'h0800_0000, 1, "srl4");
    issue(32'h1234_5678, 32'd0, 3'b100, 32'h1234_5678, 0, "sll0");
`else
    issue(32'd1, 32'd31, 3'b100, 32'd0, 0, "op100_undef");
    issue(32'hDEAD_BEEF, 32'd3, 3'b111, 32'd0, 0, "op111_undef");
`endif

    // Backpressure, then drain and a new accept in the same cycle.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_a = 32'd10; req_b = 32'd5; req_op = 3'b000;
    tick();
    req_a = 32'd1; req_b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_result", rsp_result, 32'd15);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_req_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("bp_new_valid", 32'(rsp_valid), 32'd1);
    check("bp_new_result", rsp_result, 32'd2);
    tick();
    check("bp_end_valid", 32'(rsp_valid), 32'd0);

    // Back-to-back single-cycle ops at full rate.
    req_valid = 1'b1;
    req_a = 32'd1; req_b = 32'd2; req_op = 3'b000;
    tick();
    check("b2b_1", rsp_result, 32'd3);
    req_a = 32'd4; req_b = 32'd5;
    tick();
    check("b2b_2", rsp_result, 32'd9);
    req_a = 32'd7; req_b = 32'd7; req_op = 3'b001;
    tick();
    check("b2b_3", rsp_result, 32'd0);
    check("b2b_3_zero", 32'(rsp_zero), 32'd1);
    check("b2b_3_valid", 32'(rsp_valid), 32'd1);
    req_valid = 1'b0;
    tick();
    check("b2b_end_valid", 32'(rsp_valid), 32'd0);

    // Reset while a response is waiting.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_a = 32'd10; req_b = 32'd5; req_op = 3'b000;
    tick();
    req_valid = 1'b0;
    check("rstv_pre_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    check("rstv_valid", 32'(rsp_valid), 32'd0);
    check("rstv_result", rsp_result, 32'd0);
    check("rstv_busy", 32'(busy), 32'd0);
    check("rstv_req_ready", 32'(req_ready), 32'd1);

`ifdef ALU_SHIFT_EN
    // Reset during CALC: the aborted shift must never respond.
    req_valid = 1'b1;
    req_a = 32'd1; req_b = 32'd31; req_op = 3'b100;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("rstc_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstc_valid", 32'(rsp_valid), 32'd0);
    check("rstc_result", rsp_result, 32'd0);
    check("rstc_busy", 32'(busy), 32'd0);
    check("rstc_req_ready", 32'(req_ready), 32'd1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rsp_valid) cnt++;
    end
    check("rstc_no_stale", 32'(cnt), 32'd0);
`endif

    // Randomized requests against the reference model.
    for (int n = 0; n < 200; n++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = 32'($urandom_range(0, 6));
        2: ra = 32'h8000_0000 | ra;
        default: ;
      endcase
      rexp = ref_alu(ra, rb, rop);
      issue(ra, rb, rop, rexp, $urandom_range(0, 2), $sformatf("rnd%0d_op%0d", n, rop));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
